sys_mat_array: RTL and testbench

- Parametrised weight-stationary systolic matrix unit with ROWS x COLS signed fixed-point PEs. It computes y[j] = sum_i x[i]*W[i][j] for one input vector per cycle.
- Adds over the previous generation: integer arithmetic, internal input skew and output deskew, valid/ready streaming, and double-buffered weights with a drain-then-swap commit.
- Sits between the vector load path and the accumulator/writeback stage of the tensor core.

---
 rtl/sys_mat_pkg.sv | 21 ++
 rtl/sys_mat_pe.sv | 41 ++++
 rtl/sys_mat_array.sv | 167 ++++++++++++++++
 tb/tb_sys_mat_array.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_mat_pkg.sv
// Shared definitions for the systolic matrix unit.
//   state_e  : control states of the weight-commit FSM
//   lat()    : input-accept to output-valid latency in cycles
//   elem_lsb : LSB position of element idx in a flat vector of w-bit elements
package sys_mat_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_SWAP  = 2'd2
  } state_e;

  function automatic int lat(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int elem_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sys_mat_pe.sv
// One weight-stationary processing element.
//   clock, reset : clock and asynchronous active-high clear
//   pass_left    : activation arriving from the left neighbour (or skew line)
//   sum_up       : partial sum arriving from the PE above (0 on the top row)
//   weight       : static weight from the active bank
//   pass_right   : registered activation for the right neighbour
//   sum_down     : registered partial sum for the PE below
module sys_mat_pe
  import sys_mat_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pass_left,
  input  logic [ACC_W-1:0]  sum_up,
  input  logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] pass_right,
  output logic [ACC_W-1:0]  sum_down
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  // Full-width signed product, then sign-extended into the accumulator width.
  assign prod     = (2*DATA_W)'($signed(pass_left)) * (2*DATA_W)'($signed(weight));
  assign prod_ext = ACC_W'(prod);

  // Accumulation wraps modulo 2^ACC_W; no saturation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_right <= '0;
      sum_down   <= '0;
    end else begin
      pass_right <= pass_left;
      sum_down   <= sum_up + prod_ext;
    end
  end

endmodule

// File: rtl/sys_mat_array.sv
// Weight-stationary systolic matrix unit: y[j] = sum_i x[i] * W[i][j].
//   clock, reset : clock and asynchronous active-high clear
//   in_valid/in_ready/in_data : input vector stream, x[i] at [i*DATA_W +: DATA_W]
//   w_we/w_row/w_data : write one shadow weight row, W[w_row][j] at [j*DATA_W +: DATA_W]
//   w_commit     : request shadow -> active swap (drain, then swap)
//   out_valid/out_data : one result per accepted vector, LAT cycles later
//   busy         : pipeline non-empty or swap pending
//   dbg_state    : current FSM state (S_RUN / S_DRAIN / S_SWAP)
// Handshake: an input vector is accepted on a rising edge where
// in_valid & in_ready; in_ready depends only on FSM state, never on in_valid.
// The output has no backpressure: out_valid is high for exactly one cycle per
// accepted vector.
module sys_mat_array
  import sys_mat_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ROWS*DATA_W-1:0]              in_data,
  input  logic                                w_we,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] w_row,
  input  logic [COLS*DATA_W-1:0]              w_data,
  input  logic                                w_commit,
  output logic                                out_valid,
  output logic [COLS*ACC_W-1:0]               out_data,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  localparam int LAT = lat(ROWS, COLS);
  localparam logic [1:0] ST_RUN   = S_RUN;
  localparam logic [1:0] ST_DRAIN = S_DRAIN;
  localparam logic [1:0] ST_SWAP  = S_SWAP;

  logic [1:0]        state;
  logic [LAT-1:0]    valid_sr;
  logic              accept;
  logic [DATA_W-1:0] w_act [ROWS][COLS];
  logic [DATA_W-1:0] w_shd [ROWS][COLS];
  logic [DATA_W-1:0] x_h   [ROWS][COLS];   // activation entering PE(i,j)
  logic [DATA_W-1:0] unused_pass [ROWS];   // right edge of the array goes nowhere
  logic [ACC_W-1:0]  s_v   [ROWS+1][COLS]; // partial sum entering PE(i,j) from above

  assign in_ready  = (state == ST_RUN);
  assign accept    = in_valid & in_ready;
  assign busy      = (|valid_sr) | (state != ST_RUN);
  assign out_valid = valid_sr[LAT-1];
  assign dbg_state = state;

  // Commit FSM. Drain waits for every in-flight vector to leave so none of
  // them sees a weight change partway through the array.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (w_commit) state <= ST_DRAIN;
        ST_DRAIN: if (valid_sr == '0) state <= ST_SWAP;
        ST_SWAP:  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
    end else begin
      valid_sr[0] <= accept;
      for (int i = 1; i < LAT; i++) valid_sr[i] <= valid_sr[i-1];
    end
  end

  // Shadow writes are accepted in any state; the copy in SWAP uses the shadow
  // contents from before that edge, so a write in the SWAP cycle waits for the
  // next commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          w_act[i][j] <= '0;
          w_shd[i][j] <= '0;
        end
      end
    end else begin
      if (w_we && (int'(w_row) < ROWS)) begin
        for (int j = 0; j < COLS; j++) w_shd[w_row][j] <= w_data[elem_lsb(j, DATA_W) +: DATA_W];
      end
      if (state == ST_SWAP) begin
        for (int i = 0; i < ROWS; i++) begin
          for (int j = 0; j < COLS; j++) w_act[i][j] <= w_shd[i][j];
        end
      end
    end
  end

  // Input skew: row i is delayed i cycles. Bubbles inject zero.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
    logic [DATA_W-1:0] x_in;
    assign x_in = accept ? in_data[elem_lsb(gi, DATA_W) +: DATA_W] : '0;
    if (gi == 0) begin : g_direct
      assign x_h[gi][0] = x_in;
    end else begin : g_delay
      logic [DATA_W-1:0] sr [gi];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < gi; k++) sr[k] <= '0;
        end else begin
          sr[0] <= x_in;
          for (int k = 1; k < gi; k++) sr[k] <= sr[k-1];
        end
      end
      assign x_h[gi][0] = sr[gi-1];
    end
  end

  // PE grid.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
      logic [DATA_W-1:0] pr;
      if (gi == 0) begin : g_top
        assign s_v[0][gj] = '0;
      end
      sys_mat_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clock      (clock),
        .reset      (reset),
        .pass_left  (x_h[gi][gj]),
        .sum_up     (s_v[gi][gj]),
        .weight     (w_act[gi][gj]),
        .pass_right (pr),
        .sum_down   (s_v[gi+1][gj])
      );
      if (gj < COLS-1) begin : g_pass
        assign x_h[gi][gj+1] = pr;
      end else begin : g_edge
        assign unused_pass[gi] = pr;
      end
    end
  end

  // Output deskew: column j leaves the array j cycles after column 0, so it is
  // delayed COLS-1-j cycles to line all columns up.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_col
    localparam int D = COLS - 1 - gj;
    if (D == 0) begin : g_direct
      assign out_data[gj*ACC_W +: ACC_W] = s_v[ROWS][gj];
    end else begin : g_delay
      logic [ACC_W-1:0] dq [D];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) dq[k] <= '0;
        end else begin
          dq[0] <= s_v[ROWS][gj];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign out_data[gj*ACC_W +: ACC_W] = dq[D-1];
    end
  end

endmodule

// File: tb/tb_sys_mat_array.sv
// Directed testbench for sys_mat_array at ROWS=COLS=4, DATA_W=8, ACC_W=16.
module tb_sys_mat_array;
  import sys_mat_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LAT    = 7;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   in_data  = '0;
  logic                     w_we     = 1'b0;
  logic [1:0]               w_row    = '0;
  logic [COLS*DATA_W-1:0]   w_data   = '0;
  logic                     w_commit = 1'b0;
  logic                     out_valid;
  logic [COLS*ACC_W-1:0]    out_data;
  logic                     busy;
  logic [1:0]               dbg_state;

  sys_mat_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_we      (w_we),
    .w_row     (w_row),
    .w_data    (w_data),
    .w_commit  (w_commit),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int                     n_assert = 0;
  int                     n_fail   = 0;
  logic [COLS*ACC_W-1:0]  exp_q[$];
  logic [LAT-1:0]         hist     = '0;
  logic                   acc_now  = 1'b0;
  int                     wb_act[ROWS][COLS];
  int                     wb_shd[ROWS][COLS];
  int                     cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] px(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [63:0] py(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [63:0] model(input int a, input int b, input int c, input int d);
    int x[4];
    int s;
    logic [63:0] r;
    x = '{a, b, c, d};
    r = '0;
    for (int j = 0; j < COLS; j++) begin
      s = 0;
      for (int i = 0; i < ROWS; i++) s += x[i] * wb_act[i][j];
      r[j*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    logic [63:0] e;
    @(posedge clock);
    #1;
    hist = {hist[LAT-2:0], acc_now};
    chk("out_valid", {63'd0, out_valid}, {63'd0, hist[LAT-1]});
    if (hist[LAT-1]) begin
      chk("exp_q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
      end
    end
  endtask

  task automatic send(input int a, input int b, input int c, input int d, input logic [63:0] y);
    in_valid = 1'b1;
    in_data  = px(a, b, c, d);
    chk("in_ready_send", {63'd0, in_ready}, 64'd1);
    exp_q.push_back(y);
    acc_now = 1'b1;
    tick();
    acc_now  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input int a, input int b, input int c, input int d);
    send(a, b, c, d, model(a, b, c, d));
  endtask

  task automatic wr(input int row, input int a, input int b, input int c, input int d);
    w_we   = 1'b1;
    w_row  = row[1:0];
    w_data = px(a, b, c, d);
    wb_shd[row][0] = a; wb_shd[row][1] = b; wb_shd[row][2] = c; wb_shd[row][3] = d;
    tick();
    w_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) tick();
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  // Commit with an empty pipeline: in_ready low for exactly two cycles.
  task automatic commit_empty();
    w_commit = 1'b1;
    chk("ready_pre_commit", {63'd0, in_ready}, 64'd1);
    tick();
    w_commit = 1'b0;
    chk("drain_ready", {63'd0, in_ready}, 64'd0);
    chk("drain_state", {62'd0, dbg_state}, {62'd0, S_DRAIN});
    chk("drain_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("swap_ready", {63'd0, in_ready}, 64'd0);
    chk("swap_state", {62'd0, dbg_state}, {62'd0, S_SWAP});
    tick();
    chk("run_ready", {63'd0, in_ready}, 64'd1);
    chk("run_busy", {63'd0, busy}, 64'd0);
    wb_act = wb_shd;
  endtask

  initial begin #100000; $display("FAIL watchdog: time limit reached"); $fatal(1, "timeout"); end

  initial begin
    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, {62'd0, S_RUN});
    reset = 1'b0;

    // weights are zero after reset
    send(1, 1, 1, 1, 64'd0);

    // identity: shadow writes do not reach the active bank before commit
    wr(0, 1, 0, 0, 0);
    wr(1, 0, 1, 0, 0);
    wr(2, 0, 0, 1, 0);
    wr(3, 0, 0, 0, 1);
    wait_idle();
    commit_empty();
    send(1, -2, 3, -4, py(1, -2, 3, -4));
    cnt = 1;
    while (!out_valid && cnt < 20) begin tick(); cnt++; end
    chk("latency", cnt, 64'd7);

    // full matrix W[i][j] = i + j
    wr(0, 0, 1, 2, 3);
    wr(1, 1, 2, 3, 4);
    wr(2, 2, 3, 4, 5);
    wr(3, 3, 4, 5, 6);
    wait_idle();
    commit_empty();
    send(1, 2, 3, 4, py(20, 30, 40, 50));

    // streaming: 10 back-to-back, then 3 with 2-cycle bubbles
    for (int n = 1; n <= 10; n++) send_m(n, -n, 2 * n, 1);
    for (int n = 0; n < 3; n++) begin
      send_m(-3 * n, 5, n, -7);
      repeat (2) tick();
    end

    // commit mid-stream: new shadow = 2*I
    wr(0, 2, 0, 0, 0);
    wr(1, 0, 2, 0, 0);
    wr(2, 0, 0, 2, 0);
    wr(3, 0, 0, 0, 2);
    send_m(3, -1, 4, 1);
    send_m(-5, 9, 2, 6);
    send_m(7, 7, -7, 0);
    w_commit = 1'b1;
    send(1, 2, 3, 4, py(20, 30, 40, 50));
    wb_act = wb_shd;
    in_valid = 1'b1;
    in_data  = px(5, -6, 7, -8);
    for (int k = 1; k <= 9; k++) begin
      w_commit = (k <= 5);   // held commit must not restart the sequence
      chk("midcommit_ready_low", {63'd0, in_ready}, 64'd0);
      if (k == 9) begin
        chk("midcommit_swap_state", {62'd0, dbg_state}, {62'd0, S_SWAP});
        w_commit = 1'b0;
        w_we   = 1'b1;
        w_row  = 2'd0;
        w_data = px(9, 9, 9, 9);
        wb_shd[0] = '{9, 9, 9, 9};
      end
      tick();
      w_we = 1'b0;
    end
    w_commit = 1'b0;
    chk("ready_after_swap", {63'd0, in_ready}, 64'd1);
    send(5, -6, 7, -8, py(10, -12, 14, -16));
    send(-1, 0, 1, 2, py(-2, 0, 2, 4));
    wait_idle();
    commit_empty();
    send(1, 1, 1, 1, py(9, 11, 11, 11));

    // wraparound at ACC_W = 16
    for (int r = 0; r < ROWS; r++) wr(r, 127, 0, 0, 0);
    wait_idle();
    commit_empty();
    send(127, 127, 127, 127, py(-1020, 0, 0, 0));
    wait_idle();

    // reset with 5 vectors in flight
    for (int n = 1; n <= 5; n++) send_m(n, n, n, n);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    hist = '0;
    wb_act = '{default: 0};
    wb_shd = '{default: 0};
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (10) tick();
    chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    send(1, 1, 1, 1, 64'd0);
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
